// File: rtl/game_link_pkg.sv
// game_link_pkg
// Shared definitions for the inter-board game-state link: sync byte, packet
// byte indices and lengths, scheduler FSM states, flag-byte bit positions,
// the snapshot payload record and its checksum. Used by the TX scheduler
// and intended for reuse by the receive-side deframer.
// No ports (package).
package game_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Byte positions within a packet
    localparam logic [3:0] IDX_SYNC  = 4'd0;
    localparam logic [3:0] IDX_XT_HI = 4'd1;
    localparam logic [3:0] IDX_XT_LO = 4'd2;
    localparam logic [3:0] IDX_YT_HI = 4'd3;
    localparam logic [3:0] IDX_YT_LO = 4'd4;
    localparam logic [3:0] IDX_XB_HI = 4'd5;
    localparam logic [3:0] IDX_XB_LO = 4'd6;
    localparam logic [3:0] IDX_YB_HI = 4'd7;
    localparam logic [3:0] IDX_YB_LO = 4'd8;
    localparam logic [3:0] IDX_FLAGS = 4'd9;
    localparam logic [3:0] IDX_HP    = 4'd10;
    localparam logic [3:0] IDX_CKSUM = 4'd11;

    localparam int unsigned PKT_LEN_CKSUM = 12;
    localparam int unsigned PKT_LEN_PLAIN = 11;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} tx_state_t;

    // Flags byte = {dir_enemy[2:0], dir_tank[1:0], hit, obstacle, 0}
    localparam int unsigned FLAG_OBS_BIT  = 1;
    localparam int unsigned FLAG_HIT_BIT  = 2;
    localparam int unsigned FLAG_DIRT_LSB = 3;
    localparam int unsigned FLAG_DIRE_LSB = 5;

    typedef struct packed {
        logic [9:0] xt;
        logic [9:0] yt;
        logic [9:0] xb;
        logic [9:0] yb;
        logic [7:0] flags;
        logic [7:0] hp;
    } payload_t;

    // XOR of packet bytes 1..10 (sync byte excluded)
    function automatic logic [7:0] payload_cksum(input payload_t p);
        return {6'b0, p.xt[9:8]} ^ p.xt[7:0] ^
               {6'b0, p.yt[9:8]} ^ p.yt[7:0] ^
               {6'b0, p.xb[9:8]} ^ p.xb[7:0] ^
               {6'b0, p.yb[9:8]} ^ p.yb[7:0] ^
               p.flags ^ p.hp;
    endfunction

endpackage

// File: rtl/game_tx_byte_mux.sv
// game_tx_byte_mux
// Combinational selection of one packet byte from the snapshot payload.
// Macro GAME_TX_CKSUM_EN: when defined, index 11 yields the checksum byte.
// Ports:
//   i_payload  snapshot payload record
//   i_idx      packet byte index
//   o_byte     selected byte (0 for indices past the end of the packet)
module game_tx_byte_mux
    import game_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  payload_t   i_payload,
    input  logic [3:0] i_idx,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = '0;
        case (i_idx)
            IDX_SYNC:  o_byte = SYNC_BYTE;
            IDX_XT_HI: o_byte = {6'b0, i_payload.xt[9:8]};
            IDX_XT_LO: o_byte = i_payload.xt[7:0];
            IDX_YT_HI: o_byte = {6'b0, i_payload.yt[9:8]};
            IDX_YT_LO: o_byte = i_payload.yt[7:0];
            IDX_XB_HI: o_byte = {6'b0, i_payload.xb[9:8]};
            IDX_XB_LO: o_byte = i_payload.xb[7:0];
            IDX_YB_HI: o_byte = {6'b0, i_payload.yb[9:8]};
            IDX_YB_LO: o_byte = i_payload.yb[7:0];
            IDX_FLAGS: o_byte = i_payload.flags;
            IDX_HP:    o_byte = i_payload.hp;
`ifdef GAME_TX_CKSUM_EN
            IDX_CKSUM: o_byte = payload_cksum(i_payload);
`endif
            default:   o_byte = '0;
        endcase
    end

endmodule

// File: rtl/game_state_tx_sched.sv
// game_state_tx_sched
// Per-frame packetiser/scheduler feeding the UART byte transmitter over a
// valid/ready handshake. Snapshots tank/bullet state on an accepted frame
// tick and streams it as a framed byte packet.
// Macro GAME_TX_CKSUM_EN: when defined, a 12th checksum byte is appended.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   frame_tick                   one-cycle pulse per frame
//   xpos_/ypos_tank, _bullet     positions to report (10 bit)
//   direction_enemy/_tank        bullet direction / tank heading
//   tank_hit, obstacle_hit       hit pulses, made sticky until sent
//   hp_enemy                     enemy HP
//   tx_data/tx_valid/tx_ready    byte handshake to UART TX
//   busy                         packet in flight
//   pkt_sent, tx_timeout         completion / abort pulses
//   overrun_cnt                  saturating count of dropped ticks
module game_state_tx_sched
    import game_link_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] xpos_tank,
    input  logic [9:0] ypos_tank,
    input  logic [9:0] xpos_bullet,
    input  logic [9:0] ypos_bullet,
    input  logic [2:0] direction_enemy,
    input  logic [1:0] direction_tank,
    input  logic       tank_hit,
    input  logic       obstacle_hit,
    input  logic [7:0] hp_enemy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       pkt_sent,
    output logic       tx_timeout,
    output logic [7:0] overrun_cnt
);

`ifdef GAME_TX_CKSUM_EN
    localparam int unsigned PKT_LEN = PKT_LEN_CKSUM;
`else
    localparam int unsigned PKT_LEN = PKT_LEN_PLAIN;
`endif
    localparam logic [3:0]  LAST_IDX  = 4'(PKT_LEN - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(TICK_DIV - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    tx_state_t   r_state;
    payload_t    r_payload;
    logic [3:0]  r_idx;
    logic [7:0]  r_div;
    logic [15:0] r_wait;
    logic        r_pending;
    logic        r_hit_s;
    logic        r_obs_s;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_pkt_sent;
    logic        r_tx_timeout;
    logic [7:0]  r_ovr;

    logic        w_acc_tick;
    logic [3:0]  w_next_idx;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_ovr_inc;
    payload_t    w_snap;

    assign w_acc_tick = frame_tick && (r_div == DIV_LAST);
    assign w_next_idx = r_idx + 4'd1;
    assign w_ovr_inc  = (r_ovr == 8'hFF) ? r_ovr : r_ovr + 8'd1;

    // Snapshot includes hit pulses arriving in the LOAD cycle itself
    always_comb begin
        w_snap       = '0;
        w_snap.xt    = xpos_tank;
        w_snap.yt    = ypos_tank;
        w_snap.xb    = xpos_bullet;
        w_snap.yb    = ypos_bullet;
        w_snap.hp    = hp_enemy;
        w_snap.flags[FLAG_DIRE_LSB +: 3] = direction_enemy;
        w_snap.flags[FLAG_DIRT_LSB +: 2] = direction_tank;
        w_snap.flags[FLAG_HIT_BIT]       = r_hit_s | tank_hit;
        w_snap.flags[FLAG_OBS_BIT]       = r_obs_s | obstacle_hit;
    end

    // tx_data is registered one byte ahead: the mux looks at the next index
    game_tx_byte_mux #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_mux (
        .i_payload (r_payload),
        .i_idx     (w_next_idx),
        .o_byte    (w_next_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_payload    <= '0;
            r_idx        <= '0;
            r_div        <= '0;
            r_wait       <= '0;
            r_pending    <= 1'b0;
            r_hit_s      <= 1'b0;
            r_obs_s      <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_pkt_sent   <= 1'b0;
            r_tx_timeout <= 1'b0;
            r_ovr        <= '0;
        end else begin
            r_pkt_sent   <= 1'b0;
            r_tx_timeout <= 1'b0;

            if (frame_tick)
                r_div <= w_acc_tick ? '0 : r_div + 8'd1;
            if (tank_hit)
                r_hit_s <= 1'b1;
            if (obstacle_hit)
                r_obs_s <= 1'b1;

            // Accepted tick with a packet already owed is dropped and counted;
            // LOAD handles its own pending update below.
            if (w_acc_tick && r_state != LOAD) begin
                if (r_pending)
                    r_ovr <= w_ovr_inc;
                else if (r_state != IDLE)
                    r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_acc_tick || r_pending)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_payload  <= w_snap;
                    r_hit_s    <= 1'b0;
                    r_obs_s    <= 1'b0;
                    r_pending  <= w_acc_tick;
                    r_idx      <= '0;
                    r_wait     <= '0;
                    r_tx_data  <= SYNC_BYTE;
                    r_tx_valid <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        r_wait <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= '0;
                            r_pkt_sent <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= w_next_byte;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_wait       <= '0;
                        r_tx_valid   <= 1'b0;
                        r_tx_data    <= '0;
                        r_tx_timeout <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = (r_state != IDLE);
    assign pkt_sent    = r_pkt_sent;
    assign tx_timeout  = r_tx_timeout;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_game_state_tx_sched.sv
// tb_game_state_tx_sched
// Self-checking bench for game_state_tx_sched (TICK_DIV=4, TIMEOUT_CYC=16).
// Honors GAME_TX_CKSUM_EN for the expected packet length.
module tb_game_state_tx_sched;

    localparam int TICK_DIV = 4;
    localparam int TMO      = 16;
`ifdef GAME_TX_CKSUM_EN
    localparam int PLEN = 12;
`else
    localparam int PLEN = 11;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] xpos_tank = '0, ypos_tank = '0, xpos_bullet = '0, ypos_bullet = '0;
    logic [2:0] direction_enemy = '0;
    logic [1:0] direction_tank = '0;
    logic       tank_hit = 1'b0, obstacle_hit = 1'b0;
    logic [7:0] hp_enemy = '0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid, busy, pkt_sent, tx_timeout;
    logic [7:0] overrun_cnt;

    always #5 clk = ~clk;

    game_state_tx_sched #(
        .SYNC_BYTE   (8'hA5),
        .TICK_DIV    (TICK_DIV),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .xpos_tank       (xpos_tank),
        .ypos_tank       (ypos_tank),
        .xpos_bullet     (xpos_bullet),
        .ypos_bullet     (ypos_bullet),
        .direction_enemy (direction_enemy),
        .direction_tank  (direction_tank),
        .tank_hit        (tank_hit),
        .obstacle_hit    (obstacle_hit),
        .hp_enemy        (hp_enemy),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .pkt_sent        (pkt_sent),
        .tx_timeout      (tx_timeout),
        .overrun_cnt     (overrun_cnt)
    );

    int nchk = 0;
    int npass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 snapshot, 2 streaming, 3 done. The packet itself is a
    // byte queue built arithmetically at snapshot time and popped on accept.
    logic [7:0] mq[$];
    int m_st = 0, m_div = 0, m_wait = 0, m_ovr = 0;
    bit m_pend = 0, m_hit = 0, m_obs = 0, m_sent = 0, m_tmo = 0;

    function automatic void build(input bit h, input bit o);
        logic [7:0] x;
        mq.delete();
        mq.push_back(8'hA5);
        mq.push_back(8'(xpos_tank >> 8));   mq.push_back(8'(xpos_tank % 256));
        mq.push_back(8'(ypos_tank >> 8));   mq.push_back(8'(ypos_tank % 256));
        mq.push_back(8'(xpos_bullet >> 8)); mq.push_back(8'(xpos_bullet % 256));
        mq.push_back(8'(ypos_bullet >> 8)); mq.push_back(8'(ypos_bullet % 256));
        mq.push_back(8'(direction_enemy * 32 + direction_tank * 8 + h * 4 + o * 2));
        mq.push_back(hp_enemy);
`ifdef GAME_TX_CKSUM_EN
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ mq[i];
        mq.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    task automatic model_step();
        bit acc, h, o;
        if (rst) begin
            mq.delete();
            m_st = 0; m_div = 0; m_wait = 0; m_ovr = 0;
            m_pend = 0; m_hit = 0; m_obs = 0; m_sent = 0; m_tmo = 0;
        end else begin
            acc = frame_tick && (m_div == TICK_DIV - 1);
            if (frame_tick) m_div = acc ? 0 : m_div + 1;
            m_sent = 0; m_tmo = 0;
            h = m_hit | tank_hit;
            o = m_obs | obstacle_hit;
            m_hit = h; m_obs = o;
            if (m_st == 0) begin
                if (acc && m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                if (acc || m_pend) m_st = 1;
            end else if (m_st == 1) begin
                build(h, o);
                m_hit = 0; m_obs = 0;
                m_pend = acc;
                m_wait = 0;
                m_st = 2;
            end else begin
                if (acc) begin
                    if (m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    else m_pend = 1;
                end
                if (m_st == 3) m_st = 0;
                else if (tx_ready) begin
                    void'(mq.pop_front());
                    m_wait = 0;
                    if (mq.size() == 0) begin m_st = 3; m_sent = 1; end
                end else if (m_wait == TMO - 1) begin
                    mq.delete(); m_st = 0; m_tmo = 1; m_wait = 0;
                end else m_wait++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_valid", tx_valid, (m_st == 2));
            if (m_st == 2) check("m_data", tx_data, mq[0]);
            check("m_busy", busy, (m_st != 0));
            check("m_sent", pkt_sent, m_sent);
            check("m_tmo", tx_timeout, m_tmo);
            check("m_ovr", overrun_cnt, m_ovr);
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0] got[16];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // TICK_DIV frame ticks back to back; returns in the snapshot cycle
    task automatic fire_tick();
        for (int i = 0; i < TICK_DIV; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
    endtask

    // Gathers accepted bytes until pkt_sent; optional stall of stall_len cycles
    // when stall_at bytes have been accepted.
    task automatic collect(input int stall_at, input int stall_len, output int n, output int cyc);
        int stall;
        logic [7:0] held;
        bit done;
        n = 0; cyc = 0; stall = 0; held = '0; done = 0;
        for (int k = 0; k < 80; k++) begin
            if (pkt_sent) begin done = 1; break; end
            if (tx_valid && n == stall_at && stall < stall_len) begin
                if (stall == 0) held = tx_data;
                else check("bp_hold", tx_data, held);
                tx_ready = 1'b0;
                stall++;
            end else tx_ready = 1'b1;
            if (tx_valid && tx_ready && n < 16) begin
                got[n] = tx_data;
                n++;
            end
            tick();
            cyc++;
        end
        tx_ready = 1'b1;
        check("pkt_sent_seen", done, 1);
    endtask

    typedef struct packed {
        logic [9:0]  xt, yt, xb, yb;
        logic [2:0]  de;
        logic [1:0]  dt;
        logic [7:0]  hp;
        logic [95:0] eb;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int n, cyc, sent, nb, vc;
        logic [95:0] e;

        vecs[0] = '{xt: 10'h155, yt: 10'h0AA, xb: 10'h000, yb: 10'h000, de: 3'b101, dt: 2'b10,
                    hp: 8'h64, eb: 96'hA5_01_55_00_AA_00_00_00_00_B0_64_2A};
        vecs[1] = '{xt: 10'h3FF, yt: 10'h200, xb: 10'h001, yb: 10'h2C3, de: 3'b011, dt: 2'b01,
                    hp: 8'hFF, eb: 96'hA5_03_FF_02_00_00_01_02_C3_68_FF_A9};
        vecs[2] = '{xt: 10'h000, yt: 10'h000, xb: 10'h000, yb: 10'h000, de: 3'b000, dt: 2'b00,
                    hp: 8'h00, eb: 96'hA5_00_00_00_00_00_00_00_00_00_00_00};

        // reset state
        rst = 1'b1;
        idle(2);
        check("rst_data", tx_data, 8'h00);
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sent", pkt_sent, 0);
        check("rst_tmo", tx_timeout, 0);
        check("rst_ovr", overrun_cnt, 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // table-driven packets, full-rate ready
        for (int v = 0; v < 3; v++) begin
            xpos_tank = vecs[v].xt; ypos_tank = vecs[v].yt;
            xpos_bullet = vecs[v].xb; ypos_bullet = vecs[v].yb;
            direction_enemy = vecs[v].de; direction_tank = vecs[v].dt;
            hp_enemy = vecs[v].hp;
            tx_ready = 1'b1;
            fire_tick();
            check("lat_load_valid", tx_valid, 0);
            check("lat_load_busy", busy, 1);
            tick();
            check("lat_first_valid", tx_valid, 1);
            xpos_tank = 10'($urandom); hp_enemy = 8'($urandom);
            collect(-1, 0, n, cyc);
            check("tbl_len", n, PLEN);
            check("tbl_sent_lat", cyc, PLEN);
            e = vecs[v].eb;
            for (int i = 0; i < PLEN; i++) check("tbl_byte", got[i], e[95 - 8 * i -: 8]);
            idle(3);
        end

        // backpressure at byte index 3
        xpos_tank = vecs[0].xt; ypos_tank = vecs[0].yt;
        xpos_bullet = vecs[0].xb; ypos_bullet = vecs[0].yb;
        direction_enemy = vecs[0].de; direction_tank = vecs[0].dt; hp_enemy = vecs[0].hp;
        fire_tick();
        tick();
        collect(3, 5, n, cyc);
        check("bp_len", n, PLEN);
        check("bp_cycles", cyc, PLEN + 5);
        e = vecs[0].eb;
        for (int i = 0; i < PLEN; i++) check("bp_byte", got[i], e[95 - 8 * i -: 8]);
        idle(3);

        // sticky hit three frames before the accepted tick
        direction_enemy = 3'b110; direction_tank = 2'b11;
        frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        tank_hit = 1'b1; tick(); tank_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        collect(-1, 0, n, cyc);
        check("sticky_flags_set", got[9], 8'hDC);
        idle(3);
        fire_tick();
        tick();
        collect(-1, 0, n, cyc);
        check("sticky_flags_clr", got[9], 8'hD8);
        idle(3);

        // overrun: three accepted ticks during one stalled packet
        tx_ready = 1'b0;
        fire_tick();
        fire_tick();
        check("ovr_after1", overrun_cnt, 8'd0);
        fire_tick();
        check("ovr_after2", overrun_cnt, 8'd1);
        fire_tick();
        check("ovr_after3", overrun_cnt, 8'd2);
        tx_ready = 1'b1;
        sent = 0; nb = 0;
        for (int k = 0; k < 80; k++) begin
            if (pkt_sent) sent++;
            if (tx_valid && tx_ready) nb++;
            tick();
        end
        check("ovr_pkts", sent, 2);
        check("ovr_bytes", nb, 2 * PLEN);
        check("ovr_idle", busy, 0);

        // timeout with ready stuck low
        tx_ready = 1'b0;
        fire_tick();
        tick();
        vc = 0;
        for (int k = 0; k < 40; k++) begin
            if (tx_timeout) break;
            if (tx_valid) vc++;
            tick();
        end
        check("tmo_pulse", tx_timeout, 1);
        check("tmo_wait", vc, TMO);
        check("tmo_valid", tx_valid, 0);
        check("tmo_busy", busy, 0);
        tick();
        check("tmo_one_cycle", tx_timeout, 0);
        tx_ready = 1'b1;
        idle(3);

        // reset at byte 5
        fire_tick();
        tick();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (n == 5) break;
            if (tx_valid) n++;
            tick();
        end
        check("rmid_at5", n, 5);
        rst = 1'b1;
        tick();
        check("rmid_data", tx_data, 8'h00);
        check("rmid_valid", tx_valid, 0);
        check("rmid_busy", busy, 0);
        check("rmid_sent", pkt_sent, 0);
        check("rmid_tmo", tx_timeout, 0);
        check("rmid_ovr", overrun_cnt, 8'h00);
        rst = 1'b0;
        idle(2);
        fire_tick();
        tick();
        check("rmid_restart_valid", tx_valid, 1);
        check("rmid_restart_sync", tx_data, 8'hA5);
        collect(-1, 0, n, cyc);
        check("rmid_len", n, PLEN);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            frame_tick      = ($urandom_range(5) == 0);
            tx_ready        = ($urandom_range(3) != 0);
            tank_hit        = ($urandom_range(24) == 0);
            obstacle_hit    = ($urandom_range(24) == 0);
            rst             = ($urandom_range(699) == 0);
            xpos_tank       = 10'($urandom);
            ypos_tank       = 10'($urandom);
            xpos_bullet     = 10'($urandom);
            ypos_bullet     = 10'($urandom);
            direction_enemy = 3'($urandom);
            direction_tank  = 2'($urandom);
            hp_enemy        = 8'($urandom);
            tick();
        end
        frame_tick = 1'b0; tank_hit = 1'b0; obstacle_hit = 1'b0; rst = 1'b0; tx_ready = 1'b1;
        idle(40);
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/game_state_tx_sched.md
Name: game_state_tx_sched

Overview:
Packetiser and scheduler for the inter-board game-state link. Once per frame tick it snapshots the local tank position, the bullet position, direction and hit flags, and the enemy HP. It then sequences them as a framed byte stream into the UART byte transmitter over a valid/ready handshake. It sits between the tank game logic and the UART TX core, in the 65 MHz pixel-clock domain.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every packet
TICK_DIV, 1, send on every TICK_DIV-th frame_tick (1..255)
TIMEOUT_CYC, 65535, cycles tx_valid may wait for tx_ready before the packet is aborted

Ports:
clk  in  1  65 MHz pixel clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync edge)
xpos_tank  in  10  local tank X
ypos_tank  in  10  local tank Y
xpos_bullet  in  10  bullet X
ypos_bullet  in  10  bullet Y
direction_enemy  in  3  bullet direction for enemy
direction_tank  in  2  local tank heading
tank_hit  in  1  pulse: enemy tank hit
obstacle_hit  in  1  pulse: obstacle hit
hp_enemy  in  8  enemy HP
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte
busy  out  1  packet in flight
pkt_sent  out  1  one-cycle pulse after the last byte is accepted
tx_timeout  out  1  one-cycle pulse on abort
overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, pkt_sent=0, tx_timeout=0, overrun_cnt=0. Sticky flags, pending flag and divider are cleared; FSM goes to IDLE.
- Packet layout, in order:
  - SYNC_BYTE
  - {6'b0,xpos_tank[9:8]}, xpos_tank[7:0]
  - the same hi/lo pair for ypos_tank, xpos_bullet, ypos_bullet
  - flags = {direction_enemy, direction_tank, hit_s, obs_s, 1'b0}
  - hp_enemy
  - optional checksum (see Optional Feature)
- Divider: counts frame_tick pulses. Every TICK_DIV-th tick is an accepted tick, and the divider resets to 0 on it.
- FSM IDLE -> LOAD:
  - Accepted tick in IDLE, or pending=1 in IDLE, moves to LOAD.
  - LOAD lasts 1 cycle. It snapshots all inputs into a payload register, clears pending, and clears the sticky flags.
- LOAD -> SEND:
  - tx_valid=1 is asserted the cycle after LOAD, with byte index 0.
  - Index advances only on tx_valid && tx_ready. tx_data is stable while tx_valid=1 && !tx_ready.
- SEND -> DONE: on acceptance of the last byte. DONE lasts 1 cycle with pkt_sent=1, then returns to IDLE.
- Latency: accepted tick to first tx_valid = 2 cycles.
- busy = (state != IDLE).
- Sticky hits:
  - hit_s/obs_s are set by tank_hit/obstacle_hit pulses.
  - A pulse in the LOAD cycle is included in that snapshot and not retained.
  - Pulses during SEND/DONE are held for the next packet.
- Tick while busy:
  - If pending=0, set pending=1.
  - If pending is already 1, increment overrun_cnt, saturating at 255. Never restart an in-flight packet.
- Timeout:
  - A wait counter counts consecutive cycles of tx_valid && !tx_ready.
  - On reaching TIMEOUT_CYC: tx_valid drops, tx_timeout pulses for 1 cycle, FSM goes to IDLE, and the payload is discarded.
  - The sticky flags are not restored.
- rst mid-packet: tx_valid drops the next cycle and the packet is abandoned. No partial resumption.

Optional Feature:
- Macro GAME_TX_CKSUM_EN.
- Defined: packet is 12 bytes. The last byte is the XOR of payload bytes 1..10 (SYNC excluded).
- Undefined: packet is 11 bytes with no checksum; pkt_sent follows acceptance of the hp_enemy byte.

Decomposition:
- Shared package game_link_pkg holds:
  - SYNC_BYTE default
  - packet byte-index constants (IDX_SYNC..IDX_CKSUM)
  - PKT_LEN_CKSUM=12, PKT_LEN_PLAIN=11
  - FSM state enum {IDLE, LOAD, SEND, DONE}
  - flags bit positions
  The receive-side deframer will reuse this package.
- One natural sub-module: game_tx_byte_mux, a combinational payload-register + index -> tx_data mux including the checksum.

Test Plan:
- Basic packet, GAME_TX_CKSUM_EN defined:
  - Stimulus: tx_ready=1, xpos_tank=0x155, ypos_tank=0x0AA, bullets=0, direction_enemy=3'b101, direction_tank=2'b10, hp_enemy=0x64, one frame_tick.
  - Required: bytes A5 01 55 00 AA 00 00 00 00 B0 64 2A on consecutive cycles. First tx_valid 2 cycles after the tick. pkt_sent 1 cycle after byte 0x2A.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles at byte index 3.
  - Required: tx_data=0x00 held stable, no byte skipped or duplicated, total 12 bytes.
- Sticky hit:
  - Stimulus: tank_hit pulse 3 frames before a tick, with TICK_DIV=4.
  - Required: that packet's flags bit 2 set; the next packet has bit 2 clear.
- Overrun:
  - Stimulus: tx_ready=0, three accepted ticks during one packet.
  - Required: pending set on the first tick; overrun_cnt=2 after the next two; one extra packet sent after the current one.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, tx_ready stuck low.
  - Required: tx_timeout pulse after 16 wait cycles, tx_valid=0, busy=0.
- Reset mid-packet:
  - Stimulus: rst asserted at byte 5.
  - Required: next cycle all outputs at their reset values; a fresh tick restarts from 0xA5.
